// File: rtl/fft_sequencer.sv
// Purpose : in-place radix-2 DIT FFT controller driving the fft_accelerator port (load, compute, unload).
// Latency : N load handshakes, then exactly N*LOG2N compute cycles, then N unload handshakes; done_o one cycle after the last.
// Backpr. : load stalls indefinitely on in_valid_i=0; unload holds out_data_o stable while out_ready_i=0; compute never stalls.
//
// Optional feature macro: FFT_SEQ_ABS_EN (adds abs_mode_i; UNLOAD can stream accelerator magnitudes).
//
// Ports:
//   clk_i, rst_i (async, active-high)   clock and reset
//   start_i / busy_o / done_o           transform control and status
//   in_valid_i / in_ready_o / in_data_i    sample stream in, natural order, {im[31:16], re[15:0]}
//   out_valid_o / out_ready_i / out_data_o result stream out, natural order
//   tw_addr_o / tw_data_i               twiddle ROM lookup (combinational return)
//   fft_sel_o, fft_operator_o, fft_operand_{a,b,c}_o, fft_result_i   accelerator request/response
//   abs_mode_i (FFT_SEQ_ABS_EN only)    magnitude output select, sampled with start_i
module fft_sequencer #(
    parameter int LOG2N = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_data_o,
    output logic [LOG2N-2:0]  tw_addr_o,
    input  logic [31:0]       tw_data_i,
    output logic              fft_sel_o,
    output logic [4:0]        fft_operator_o,
    output logic [31:0]       fft_operand_a_o,
    output logic [31:0]       fft_operand_b_o,
    output logic [31:0]       fft_operand_c_o,
    input  logic [31:0]       fft_result_i
`ifdef FFT_SEQ_ABS_EN
    ,
    input  logic              abs_mode_i
`endif
);

    localparam int N  = 1 << LOG2N;
    localparam int SW = 4;  // stage counter width, covers LOG2N up to 8

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_BFLY_C = 3'd2;
    localparam logic [2:0] S_BFLY_D = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;

    localparam logic [4:0] OP_BFLY_C  = 5'b00000;
    localparam logic [4:0] OP_BFLY_D  = 5'b00001;
    localparam logic [4:0] OP_ABS     = 5'b00100;
    localparam logic [4:0] OP_BITREV  = 5'b00101;

    logic [2:0]        state_q;
    logic [LOG2N-1:0]  cnt_q;      // load count, then output count
    logic [LOG2N-2:0]  k_q;        // butterfly index within a stage
    logic [SW-1:0]     s_q;        // stage
    logic [31:0]       c_hold_q;   // upper butterfly result held across BFLY_C -> BFLY_D
    logic              done_q;
    logic [31:0]       mem_q [N];

`ifdef FFT_SEQ_ABS_EN
    logic              abs_q;
`endif

    // Butterfly addressing for stage s, butterfly k.
    logic [LOG2N-1:0]  k_ext;
    logic [LOG2N-1:0]  half;
    logic [LOG2N-1:0]  j_idx;
    logic [LOG2N-1:0]  ia;
    logic [LOG2N-1:0]  ib;
    logic [LOG2N-2:0]  tw_idx;

    assign k_ext  = {1'b0, k_q};
    assign half   = {{(LOG2N-1){1'b0}}, 1'b1} << s_q;
    assign j_idx  = k_ext & (half - 1'b1);
    // Bit s of ia is always zero, so ib can be formed with an OR.
    assign ia     = ((k_ext >> s_q) << (s_q + 1'b1)) | j_idx;
    assign ib     = ia | half;
    // j < 2^s, so j fits in LOG2N-1 bits and the shifted value never overflows.
    assign tw_idx = j_idx[LOG2N-2:0] << (SW'(LOG2N-1) - s_q);

    logic in_hs;
    logic out_hs;
    logic last_bfly;

    assign in_hs     = (state_q == S_LOAD) && in_valid_i;
    assign out_hs    = (state_q == S_UNLOAD) && out_ready_i;
    assign last_bfly = (s_q == SW'(LOG2N-1)) && (k_q == '1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            s_q      <= '0;
            c_hold_q <= '0;
            done_q   <= 1'b0;
`ifdef FFT_SEQ_ABS_EN
            abs_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_LOAD;
                        cnt_q   <= '0;
                        k_q     <= '0;
                        s_q     <= '0;
`ifdef FFT_SEQ_ABS_EN
                        abs_q   <= abs_mode_i;
`endif
                    end
                end
                S_LOAD: begin
                    if (in_hs) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == '1) begin
                            state_q <= S_BFLY_C;
                            k_q     <= '0;
                            s_q     <= '0;
                        end
                    end
                end
                S_BFLY_C: begin
                    c_hold_q <= fft_result_i;
                    state_q  <= S_BFLY_D;
                end
                S_BFLY_D: begin
                    k_q <= k_q + 1'b1;
                    if (k_q == '1) begin
                        s_q <= s_q + 1'b1;
                    end
                    if (last_bfly) begin
                        state_q <= S_UNLOAD;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_BFLY_C;
                    end
                end
                S_UNLOAD: begin
                    if (out_hs) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == '1) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Sample buffer: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk_i) begin
        if (in_hs) begin
            // The accelerator returns the bit-reversed load index this cycle.
            mem_q[fft_result_i[LOG2N-1:0]] <= in_data_i;
        end
        if (state_q == S_BFLY_D) begin
            mem_q[ia] <= c_hold_q;
            mem_q[ib] <= fft_result_i;
        end
    end

    always_comb begin
        busy_o          = (state_q != S_IDLE);
        done_o          = done_q;
        in_ready_o      = 1'b0;
        out_valid_o     = 1'b0;
        out_data_o      = '0;
        tw_addr_o       = '0;
        fft_sel_o       = 1'b0;
        fft_operator_o  = '0;
        fft_operand_a_o = '0;
        fft_operand_b_o = '0;
        fft_operand_c_o = '0;
        case (state_q)
            S_LOAD: begin
                in_ready_o      = 1'b1;
                fft_sel_o       = 1'b1;
                fft_operator_o  = OP_BITREV;
                fft_operand_a_o = 32'(cnt_q);
                fft_operand_b_o = 32'(32 - LOG2N);
            end
            S_BFLY_C, S_BFLY_D: begin
                fft_sel_o       = 1'b1;
                fft_operator_o  = (state_q == S_BFLY_C) ? OP_BFLY_C : OP_BFLY_D;
                fft_operand_a_o = mem_q[ia];
                fft_operand_b_o = mem_q[ib];
                fft_operand_c_o = tw_data_i;
                tw_addr_o       = tw_idx;
            end
            S_UNLOAD: begin
                out_valid_o = 1'b1;
`ifdef FFT_SEQ_ABS_EN
                if (abs_q) begin
                    fft_sel_o       = 1'b1;
                    fft_operator_o  = OP_ABS;
                    fft_operand_a_o = mem_q[cnt_q];
                    out_data_o      = fft_result_i;
                end else begin
                    out_data_o = mem_q[cnt_q];
                end
`else
                out_data_o = mem_q[cnt_q];
`endif
            end
            default: begin
            end
        endcase
    end

endmodule
